// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter:
// the one-hot state encodings and the default frame/oversampling constants.
package uart_pkg;

   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;

   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      START = 5'b00010,
      DATA  = 5'b00100,
      STOP  = 5'b01000,
      BREAK = 5'b10000
   } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchronizer for the asynchronous serial line. It resets to 1
// so that an idle-high line is not mistaken for a start bit when reset is
// released.
module uart_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_count,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_ff;

   // shift the raw line through the flop chain
   always_ff @(posedge clk or negedge rst_count) begin
      if (!rst_count) begin
         sync_ff <= '1;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit,
// no parity. Bits are sampled at their centre using the shared oversampled
// baud tick; good bytes are presented on d_out with a one-cycle rx_done,
// a low stop bit gives a one-cycle frame_err.
//
// state | meaning
// IDLE  | line high, waiting for a falling edge (level-detected, no tick needed)
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling data bits at their centres, LSB first
// STOP  | sampling the stop bit; strobes rx_done or frame_err
// BREAK | stop bit was low; wait for the line to return high
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = DEF_DATA_BITS,
   parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_count,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] d_out,
   output logic                 rx_done,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   uart_state_t          state;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 rx_s;

   uart_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .rst_count (rst_count),
      .d         (rx),
      .q         (rx_s)
   );

   // frame sequencing, bit sampling and registered strobes
   always_ff @(posedge clk or negedge rst_count) begin
      if (!rst_count) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         d_out     <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state    <= START;
                  tick_cnt <= '0;
               end
            end
            START: begin
               if (baud_tick) begin
                  if (tick_cnt == TICK_MID) begin
                     if (!rx_s) begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (baud_tick) begin
                  if (tick_cnt == TICK_END) begin
                     shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                     tick_cnt  <= '0;
                     if (bit_cnt == BIT_LAST) begin
                        state <= STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (baud_tick) begin
                  if (tick_cnt == TICK_END) begin
                     tick_cnt <= '0;
                     if (rx_s) begin
                        d_out   <= shift_reg;
                        rx_done <= 1'b1;
                        state   <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            BREAK: begin
               // level-based exit so a held-low line cannot look like a new start
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios followed by random
// frames, checked against a frame-level model (queue of expected bytes,
// expected strobe counts and centre-of-stop-bit timing).
module tb_uart_rx;

   localparam int BIT_CLK = 64;

   logic       clk       = 1'b0;
   logic       rst_count = 1'b0;
   logic       baud_tick = 1'b0;
   logic       rx        = 1'b1;
   logic [7:0] d_out;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   uart_rx #(
      .DATA_BITS   (8),
      .OVERSAMPLE  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_count (rst_count),
      .baud_tick (baud_tick),
      .rx        (rx),
      .d_out     (d_out),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         n_done = 0;
   int         n_ferr = 0;
   int         last_strobe_cyc = 0;
   int         last_done_cyc = 0;
   int         prev_done_cyc = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_good = 8'h00;
   logic [7:0] exp_b;
   bit         tick_en = 1'b1;
   int         div = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // one tick every 4 clk, gated for the frozen-tick scenario
   always @(negedge clk) begin
      div = (div + 1) % 4;
      baud_tick = tick_en && (div == 0);
   end

   // strobe monitor: every rx_done must match the next expected byte
   always @(negedge clk) begin
      if (rst_count === 1'b1) begin
         if (rx_done === 1'b1 || frame_err === 1'b1)
            chk("strobe_excl", {31'd0, rx_done & frame_err}, 0);
         if (rx_done === 1'b1) begin
            n_done++;
            last_strobe_cyc = cyc;
            prev_done_cyc   = last_done_cyc;
            last_done_cyc   = cyc;
            chk("done_has_exp", {31'd0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) begin
               exp_b = exp_q.pop_front();
               chk("d_out", {24'd0, d_out}, {24'd0, exp_b});
               last_good = exp_b;
            end
         end
         if (frame_err === 1'b1) begin
            n_ferr++;
            last_strobe_cyc = cyc;
         end
      end
   end

   // drives one frame starting at a negedge; pause_bit freezes ticks for 100 clk
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int pause_bit);
      logic [9:0] bits;
      int d0, f0, stop_cyc, lat;
      bits = {stop_v, b, 1'b0};
      d0 = n_done;
      f0 = n_ferr;
      stop_cyc = 0;
      if (stop_v) exp_q.push_back(b);
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         if (i == 9) stop_cyc = cyc;
         if (i == pause_bit) begin
            tick_en = 1'b0;
            repeat (100) @(negedge clk);
            tick_en = 1'b1;
         end
         if (i == 0) begin
            repeat (8) @(negedge clk);
            chk("busy_start", {31'd0, busy}, 1);
            repeat (BIT_CLK - 8) @(negedge clk);
         end else begin
            repeat (BIT_CLK) @(negedge clk);
         end
      end
      chk("n_done", n_done - d0, stop_v ? 1 : 0);
      chk("n_ferr", n_ferr - f0, stop_v ? 0 : 1);
      lat = last_strobe_cyc - stop_cyc;
      chk("stop_lat", {31'd0, (lat >= 28) && (lat <= 40)}, 1);
   endtask

   initial begin
      int d0, f0, gap, pb;
      logic [7:0] b;
      bit bad, prev_bad;

      // reset state
      repeat (5) @(negedge clk);
      chk("rst_d_out", {24'd0, d_out}, 0);
      chk("rst_done", {31'd0, rx_done}, 0);
      chk("rst_ferr", {31'd0, frame_err}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      rst_count = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 0);

      // 1: single valid frame
      send_frame(8'hA5, 1'b1, -1);
      rx = 1'b1;
      repeat (20) @(negedge clk);

      // 2: back-to-back, no idle gap
      send_frame(8'h00, 1'b1, -1);
      send_frame(8'hFF, 1'b1, -1);
      chk("b2b_spacing", last_done_cyc - prev_done_cyc, 640);
      repeat (20) @(negedge clk);

      // 3: short low glitch is rejected at mid start bit
      d0 = n_done;
      f0 = n_ferr;
      rx = 1'b0;
      repeat (6) @(negedge clk);
      chk("glitch_busy", {31'd0, busy}, 1);
      repeat (6) @(negedge clk);
      rx = 1'b1;
      repeat (60) @(negedge clk);
      chk("glitch_done", n_done - d0, 0);
      chk("glitch_ferr", n_ferr - f0, 0);
      chk("glitch_idle", {31'd0, busy}, 0);

      // 4: low stop bit followed by a long break
      send_frame(8'h3C, 1'b0, -1);
      d0 = n_done;
      f0 = n_ferr;
      repeat (20 * BIT_CLK) @(negedge clk);
      chk("brk_done", n_done - d0, 0);
      chk("brk_ferr", n_ferr - f0, 0);
      chk("brk_busy", {31'd0, busy}, 1);
      chk("brk_d_out", {24'd0, d_out}, {24'd0, last_good});
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("brk_release", {31'd0, busy}, 0);
      send_frame(8'h81, 1'b1, -1);
      rx = 1'b1;
      repeat (20) @(negedge clk);

      // 5: reset in the middle of the data bits of 0x5A
      d0 = n_done;
      rx = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         b = 8'h5A;
         rx = b[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      rst_count = 1'b0;
      #1;
      chk("mid_rst_d_out", {24'd0, d_out}, 0);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_done", {31'd0, rx_done}, 0);
      chk("mid_rst_ferr", {31'd0, frame_err}, 0);
      last_good = 8'h00;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      rst_count = 1'b1;
      repeat (10) @(negedge clk);
      chk("mid_rst_nodone", n_done - d0, 0);
      send_frame(8'h5A, 1'b1, -1);
      rx = 1'b1;
      repeat (10) @(negedge clk);

      // 6: ticks frozen for 100 clk mid-frame
      send_frame(8'hC3, 1'b1, 4);
      rx = 1'b1;
      repeat (10) @(negedge clk);

      // random frames, occasional bad stop and tick pause
      prev_bad = 1'b0;
      for (int n = 0; n < 14; n++) begin
         b   = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 5) == 0);
         pb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
         gap = $urandom_range(0, 40);
         if (prev_bad && gap < 8) gap = 8;
         rx = 1'b1;
         repeat (gap) @(negedge clk);
         send_frame(b, !bad, pb);
         if (bad) chk("rnd_keep", {24'd0, d_out}, {24'd0, last_good});
         prev_bad = bad;
      end
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("exp_q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
